// File: rtl/ram64_copy_engine.sv
// Block copy engine acting as bus initiator for a RAM64-style memory.
// Optional fill mode is compiled in with RAMCPY_FILL_EN.
module ram64_copy_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W:0]   count_clamped;
    logic              fill_go;
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    assign count_clamped = (count > DEPTH) ? DEPTH : count;

`ifdef RAMCPY_FILL_EN
    assign fill_go = mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state_q == IDLE && start) begin
            fill_q     <= mode;
            fill_val_q <= fill_value;
        end
    end
`else
    assign fill_go    = 1'b0;
    assign fill_q     = 1'b0;
    assign fill_val_q = '0;

    logic unused_fill_inputs;
    assign unused_fill_inputs = ^{mode, fill_value};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= count_clamped;
                    end
                end
                READ: data_reg <= ram_out;
                WRITE: begin
                    // pointers wrap naturally at the address width
                    src_ptr   <= src_ptr + 1'b1;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        ram_in      = '0;
        ram_load    = 1'b0;
        ram_address = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_clamped == '0) begin
                        state_d = DONE;
                    end else if (fill_go) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                busy        = 1'b1;
                ram_address = src_ptr;
                state_d     = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                ram_address = dst_ptr;
                ram_in      = fill_q ? fill_val_q : data_reg;
                ram_load    = 1'b1;
                if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end else if (fill_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram64_copy_engine.sv
// Directed bench for ram64_copy_engine with a RAM64 model and write scoreboard.
// Expectations for fill mode follow RAMCPY_FILL_EN.
module tb_ram64_copy_engine;

`ifdef RAMCPY_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [5:0]  src_addr;
    logic [5:0]  dst_addr;
    logic [6:0]  count;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [5:0]  ram_address;
    logic [15:0] ram_out;

    logic [15:0] mem [64];
    logic [15:0] model [64];
    logic [21:0] sb [$];
    logic [5:0]  addr_log [$];
    int          total;
    int          bad;
    int          wr_cnt;

    ram64_copy_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .count       (count),
        .fill_value  (fill_value),
        .busy        (busy),
        .done        (done),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_out = mem[ram_address];

    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    // scoreboard: every observed write must match the next expected one
    always @(negedge clk) begin
        if (ram_load) begin
            wr_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL unexpected_write: got addr=%0d data=%h want none",
                       ram_address, ram_in);
            end else begin
                logic [21:0] exp;
                exp = sb.pop_front();
                assert ({ram_address, ram_in} === exp) else begin
                    bad++;
                    $error("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                           ram_address, ram_in, exp[21:16], exp[15:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_mem(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== model[i]) diff++;
        end
        check(tag, diff, 0);
    endtask

    task automatic set_word(input int a, input logic [15:0] d);
        mem[a]   = d;
        model[a] = d;
    endtask

    task automatic run_xfer(input string tag, input int src, input int dst,
                            input int cnt, input logic md,
                            input logic [15:0] fv, input int exp_done,
                            input int exp_busy, input bit poke);
        int n;
        int done_c;
        int busy_cnt;
        int busy_last;
        logic [5:0]  a;
        logic [15:0] d;
        n = (cnt > 64) ? 64 : cnt;
        for (int i = 0; i < n; i++) begin
            a = 6'((dst + i) % 64);
            d = (md && FILL) ? fv : model[(src + i) % 64];
            model[a] = d;
            sb.push_back({a, d});
        end
        addr_log.delete();
        wr_cnt     = 0;
        done_c     = 0;
        busy_cnt   = 0;
        busy_last  = 0;
        src_addr   = 6'(src);
        dst_addr   = 6'(dst);
        count      = 7'(cnt);
        mode       = md;
        fill_value = fv;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                busy_last = c;
                addr_log.push_back(ram_address);
            end
            if (poke && c == 3) begin
                start    = 1'b1;
                src_addr = 6'd40;
                dst_addr = 6'd50;
                count    = 7'd9;
                mode     = 1'b1;
            end
            if (poke && c == 4) start = 1'b0;
            if (done) begin
                done_c = c;
                break;
            end
        end
        check({tag, "_done_cycle"}, done_c, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_busy_last"}, busy_last, (exp_busy > 0) ? exp_done - 1 : 0);
        check({tag, "_writes"}, wr_cnt, n);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, busy}, 2'b00);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check_mem({tag, "_mem"});
        mode = 1'b0;
    endtask

    initial begin
        bit saw_done;
        total      = 0;
        bad        = 0;
        wr_cnt     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        count      = '0;
        fill_value = '0;
        for (int i = 0; i < 64; i++) set_word(i, 16'h0100 + 16'(i));

        repeat (2) @(negedge clk);
        check("reset_outs", {busy, done, ram_load}, 3'b000);
        check("reset_addr", ram_address, 0);
        check("reset_in", ram_in, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_outs", {busy, done, ram_load, ram_address}, 0);

        run_xfer("basic", 0, 32, 4, 1'b0, 16'h0, 9, 8, 1'b0);

        set_word(62, 16'hAAAA);
        set_word(63, 16'hBBBB);
        set_word(0, 16'hCCCC);
        run_xfer("wrap", 62, 1, 3, 1'b0, 16'h0, 7, 6, 1'b0);
        begin
            logic [5:0] seq [6];
            seq = '{6'd62, 6'd1, 6'd63, 6'd2, 6'd0, 6'd3};
            check("wrap_addr_len", addr_log.size(), 6);
            for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
                check($sformatf("wrap_addr%0d", i), addr_log[i], seq[i]);
            end
        end

        run_xfer("zero", 5, 9, 0, 1'b0, 16'h0, 1, 0, 1'b0);
        run_xfer("clamp", 5, 20, 100, 1'b0, 16'h0, 129, 128, 1'b0);

        set_word(0, 16'h0005);
        run_xfer("overlap", 0, 1, 3, 1'b0, 16'h0, 7, 6, 1'b1);
        check("overlap_word3", mem[3], 16'h0005);

        // reset mid-transfer: only the first destination word is written
        sb.push_back({6'd40, model[10]});
        model[40] = model[10];
        wr_cnt   = 0;
        src_addr = 6'd10;
        dst_addr = 6'd40;
        count    = 7'd8;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_outs", {busy, done, ram_load}, 3'b000);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        check("rst_writes", wr_cnt, 1);
        check("rst_sb_empty", sb.size(), 0);
        check_mem("rst_mem");

        if (FILL) begin
            run_xfer("fill", 50, 10, 5, 1'b1, 16'hBEEF, 6, 5, 1'b0);
            check("fill_word14", mem[14], 16'hBEEF);
        end else begin
            run_xfer("fill", 50, 10, 5, 1'b1, 16'hBEEF, 11, 10, 1'b0);
            check("fill_word14", mem[14], model[54]);
        end

        run_xfer("after", 12, 30, 2, 1'b0, 16'h0, 5, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
